// File: rtl/name_entry_ctrl.sv
// name_entry_ctrl: high-score name entry. Converts one-cycle button pulses into a
// NUM_CHARS-character name plus a cursor position, and pulses done on commit.
// Optional idle-timeout auto-commit is compiled in with `define NAME_ENTRY_TIMEOUT_EN.
module name_entry_ctrl #(
  parameter int          CHAR_W         = 5,
  parameter int          NUM_CHARS      = 3,
  parameter int          ALPHA_SIZE     = 26,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               btn_up,
  input  logic                               btn_down,
  input  logic                               btn_left,
  input  logic                               btn_right,
  input  logic                               btn_ok,
  output logic [$clog2(NUM_CHARS+1)-1:0]     input_pos,
  output logic [CHAR_W*NUM_CHARS-1:0]        player_name,
  output logic                               active,
  output logic                               done
);

  localparam int POS_W = $clog2(NUM_CHARS + 1);
  localparam logic [POS_W-1:0]  CONFIRM_POS = POS_W'(NUM_CHARS);
  localparam logic [CHAR_W-1:0] LAST_CODE   = CHAR_W'(ALPHA_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT,
    S_COMMIT
  } state_t;

  state_t state_q, state_d;
  logic [POS_W-1:0]                  pos_d;
  // Slot i holds the character shown at cursor position NUM_CHARS-1-i, so ch0 lands in the MSBs.
  logic [NUM_CHARS-1:0][CHAR_W-1:0]  name_q, name_d;
  logic                              active_d, done_d;

`ifdef NAME_ENTRY_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        any_btn;
  assign any_btn = btn_up | btn_down | btn_left | btn_right | btn_ok;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign player_name = name_q;

  // Next-state, cursor and character update; one action per cycle in priority order.
  always_comb begin
    state_d = state_q;
    pos_d   = input_pos;
    name_d  = name_q;
`ifdef NAME_ENTRY_TIMEOUT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EDIT;
          pos_d   = '0;
          name_d  = '0;
        end
      end
      S_EDIT: begin
        if (btn_ok) begin
          if (input_pos == CONFIRM_POS) state_d = S_COMMIT;
          else                          pos_d   = input_pos + 1'b1;
        end else if (btn_left ^ btn_right) begin
          if (btn_right) pos_d = (input_pos == CONFIRM_POS) ? '0 : input_pos + 1'b1;
          else           pos_d = (input_pos == '0) ? CONFIRM_POS : input_pos - 1'b1;
        end else if ((input_pos != CONFIRM_POS) && (btn_up ^ btn_down)) begin
          for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            if (input_pos == POS_W'(NUM_CHARS - 1 - i)) begin
              if (btn_up) name_d[i] = (name_q[i] == LAST_CODE) ? '0 : name_q[i] + 1'b1;
              else        name_d[i] = (name_q[i] == '0) ? LAST_CODE : name_q[i] - 1'b1;
            end
          end
        end
`ifdef NAME_ENTRY_TIMEOUT_EN
        // Buttons restart the idle count; the timeout never overrides a button action.
        if (any_btn)                                 cnt_d   = '0;
        else if (cnt_q == TIMEOUT_CYCLES - 32'd1)    state_d = S_COMMIT;
        else                                         cnt_d   = cnt_q + 32'd1;
`endif
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    active_d = (state_d == S_EDIT);
    done_d   = (state_d == S_COMMIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      input_pos <= '0;
      name_q    <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
`ifdef NAME_ENTRY_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      input_pos <= pos_d;
      name_q    <= name_d;
      active    <= active_d;
      done      <= done_d;
`ifdef NAME_ENTRY_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_name_entry_ctrl.sv
// Testbench for name_entry_ctrl: reference model feeds an expected-value queue,
// each scenario task pops and compares after every clock, plus fixed-value checks.
module tb_name_entry_ctrl;

  localparam int TO = 16;

  // Stimulus vector {rst,start,up,down,left,right,ok}
  localparam logic [6:0] NOP = 7'b0000000;
  localparam logic [6:0] RS  = 7'b1000000;
  localparam logic [6:0] ST  = 7'b0100000;
  localparam logic [6:0] UP  = 7'b0010000;
  localparam logic [6:0] DN  = 7'b0001000;
  localparam logic [6:0] LF  = 7'b0000100;
  localparam logic [6:0] RT  = 7'b0000010;
  localparam logic [6:0] OK  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_ok = 1'b0;
  logic [1:0]  input_pos;
  logic [14:0] player_name;
  logic        active, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] exp_q[$];
  logic [18:0] e;

  // Reference model state: 0 idle, 1 edit, 2 commit
  int m_state = 0, m_pos = 0, m_cnt = 0;
  int m_ch[3] = '{0, 0, 0};

  name_entry_ctrl #(
    .CHAR_W(5),
    .NUM_CHARS(3),
    .ALPHA_SIZE(26),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_ok(btn_ok),
    .input_pos(input_pos),
    .player_name(player_name),
    .active(active),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic [6:0] v);
    logic rs, s, u, d, l, r, o;
    {rs, s, u, d, l, r, o} = v;
    if (rs) begin
      m_state = 0; m_pos = 0; m_ch = '{0, 0, 0}; m_cnt = 0;
    end else begin
      case (m_state)
        0: if (s) begin m_state = 1; m_pos = 0; m_ch = '{0, 0, 0}; m_cnt = 0; end
        1: begin
          if (o) begin
            if (m_pos == 3) m_state = 2; else m_pos = m_pos + 1;
          end else if (l != r) begin
            m_pos = r ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
          end else if (m_pos < 3 && u != d) begin
            m_ch[m_pos] = u ? (m_ch[m_pos] + 1) % 26 : (m_ch[m_pos] + 25) % 26;
          end
`ifdef NAME_ENTRY_TIMEOUT_EN
          if (u | d | l | r | o)  m_cnt = 0;
          else if (m_cnt == TO - 1) begin m_state = 2; m_cnt = 0; end
          else                    m_cnt = m_cnt + 1;
`endif
        end
        default: m_state = 0;
      endcase
    end
  endtask

  function automatic logic [18:0] model_out();
    return {2'(m_pos), 5'(m_ch[0]), 5'(m_ch[1]), 5'(m_ch[2]), m_state == 1, m_state == 2};
  endfunction

  function automatic logic [18:0] observed();
    return {input_pos, player_name, active, done};
  endfunction

  task automatic apply(input logic [6:0] v);
    {rst, start, btn_up, btn_down, btn_left, btn_right, btn_ok} = v;
    model_step(v);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    {rst, start, btn_up, btn_down, btn_left, btn_right, btn_ok} = NOP;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(RS);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL reset step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if (observed() !== 19'h0) begin n_bad++; $display("FAIL reset_const: dut=%h want=%h", observed(), 19'h0); end
  endtask

  task automatic test_wrap();
    logic [6:0] seq[$];
    seq = '{RS, ST, DN};
    foreach (seq[i]) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL wrap step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if (player_name[14:10] !== 5'd25) begin n_bad++; $display("FAIL wrap_down: ch0=%0d want=25", player_name[14:10]); end
    apply(UP);
    e = exp_q.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL wrap up1: dut=%h model=%h", observed(), e); end
    n_cmp++;
    if (player_name[14:10] !== 5'd0) begin n_bad++; $display("FAIL wrap_up: ch0=%0d want=0", player_name[14:10]); end
    for (int i = 0; i < 26; i++) begin
      apply(UP);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL wrap up26 step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if (player_name !== 15'h0) begin n_bad++; $display("FAIL wrap_full: name=%h want=0000", player_name); end
  endtask

  task automatic test_commit();
    logic [6:0] seq[$];
    int pulses;
    seq = '{RS, ST, UP, UP, OK, UP, OK, OK, OK};
    foreach (seq[i]) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL commit step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if ({done, active, player_name} !== {1'b1, 1'b0, 15'h0820}) begin
      n_bad++; $display("FAIL commit_done: done=%b active=%b name=%h want 1/0/0820", done, active, player_name);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      apply(i == 2 ? UP : NOP);
      if (done) pulses++;
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL commit after %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if ({pulses[1:0], active, player_name} !== {2'd0, 1'b0, 15'h0820}) begin
      n_bad++; $display("FAIL commit_hold: extra_done=%0d active=%b name=%h want 0/0/0820", pulses, active, player_name);
    end
  endtask

  task automatic test_cursor();
    logic [6:0] seq[$];
    logic [1:0] want_pos[$];
    seq      = '{RS, ST, LF, UP, RT, LF | RT, OK | UP, UP | DN, RT, RT, RT};
    want_pos = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    foreach (seq[i]) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL cursor step %0d: dut=%h model=%h", i, observed(), e); end
      n_cmp++;
      if (input_pos !== want_pos[i] || player_name !== 15'h0) begin
        n_bad++; $display("FAIL cursor_const step %0d: pos=%0d name=%h want pos=%0d name=0000", i, input_pos, player_name, want_pos[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] seq[$];
    int pulses;
    pulses = 0;
    seq = '{RS, ST, UP, UP, UP, OK, UP, UP, UP, UP, OK, UP, UP, UP, UP, UP, ST, NOP};
    foreach (seq[i]) begin
      apply(seq[i]);
      if (done) pulses++;
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL abort step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if ({active, input_pos, player_name} !== {1'b1, 2'd2, 15'h0C85}) begin
      n_bad++; $display("FAIL abort_start_ignored: active=%b pos=%0d name=%h want 1/2/0c85", active, input_pos, player_name);
    end
    apply(RS);
    if (done) pulses++;
    e = exp_q.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL abort rst: dut=%h model=%h", observed(), e); end
    apply(NOP);
    if (done) pulses++;
    e = exp_q.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL abort idle: dut=%h model=%h", observed(), e); end
    n_cmp++;
    if (pulses != 0 || observed() !== 19'h0) begin
      n_bad++; $display("FAIL abort_const: done_pulses=%0d out=%h want 0/00000", pulses, observed());
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] seq[$];
    seq = '{RS, ST, UP, OK, OK, OK, OK, ST, ST, DN, LF, OK, ST};
    foreach (seq[i]) begin
      apply(seq[i]);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL b2b step %0d: dut=%h model=%h", i, observed(), e); end
    end
  endtask

  task automatic test_random();
    logic [6:0] v;
    int r;
    apply(RS);
    e = exp_q.pop_front(); n_cmp++;
    if (observed() !== e) begin n_bad++; $display("FAIL random init: dut=%h model=%h", observed(), e); end
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       v = RS;
      else if (r < 10) v = ST;
      else if (r < 80) v = 7'(1 << $urandom_range(0, 4));
      else             v = 7'($urandom_range(0, 31));
      apply(v);
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL random step %0d in=%b: dut=%h model=%h", i, v, observed(), e); end
    end
  endtask

`ifdef NAME_ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    int pulses;
    pulses = 0;
    apply(RS); void'(exp_q.pop_front());
    apply(ST); void'(exp_q.pop_front());
    apply(OK); void'(exp_q.pop_front());
    for (int i = 0; i < 22; i++) begin
      apply(NOP);
      if (done) pulses++;
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL timeout step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL timeout_pulses: got=%0d want=1", pulses); end
    pulses = 0;
    apply(ST); void'(exp_q.pop_front());
    for (int i = 0; i < 45; i++) begin
      apply((i % 10 == 9) ? UP : NOP);
      if (done) pulses++;
      e = exp_q.pop_front(); n_cmp++;
      if (observed() !== e) begin n_bad++; $display("FAIL timeout_kept step %0d: dut=%h model=%h", i, observed(), e); end
    end
    n_cmp++;
    if (pulses != 0 || active !== 1'b1) begin
      n_bad++; $display("FAIL timeout_kept_alive: pulses=%0d active=%b want 0/1", pulses, active);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_wrap();
    test_commit();
    test_cursor();
    test_abort();
    test_back_to_back();
`ifdef NAME_ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
